sr_mem_arbiter: RTL and testbench
=================================

// Module: sr_mem_arbiter
// PURPOSE
//  Shares the single-port byte-addressed data memory between two requesters:
//  port C (core load/store unit) and port D (debug/program loader). Arbitrates
//  round-robin, registers each access, checks size/alignment/range, and returns a
//  registered response over a valid/ready handshake. Sits between the core and sr_mem.
// PARAMETERS
//  DEPTH   256   memory size in bytes; must match the sr_mem DEPTH it drives
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  c_req_valid  in   1   core request valid
//  c_req_ready  out  1   core request accepted this cycle
//  c_addr       in   32  core byte address
//  c_wdata      in   32  core store data; low bytes used for byte/half
//  c_we         in   1   1=store, 0=load
//  c_size       in   2   00=byte 01=half 10=word 11=illegal
//  c_sign       in   1   sign-extend load data
//  c_rsp_valid  out  1   core response valid
//  c_rsp_ready  in   1   core consumes response
//  c_rdata      out  32  load data (0 for stores or errors)
//  c_err        out  1   access faulted; memory untouched
//  d_*          --   --  identical set for the debug port (d_req_valid ... d_err)
//  mem_addr     out  32  to sr_mem data_addr
//  mem_wdata    out  32  to sr_mem write_data
//  mem_we       out  1   to sr_mem we
//  mem_sign     out  1   to sr_mem sign
//  mem_byte_w / mem_half_w / mem_word_w  out 1 each  one-hot size to sr_mem
//  mem_rdata    in   32  from sr_mem read_data (combinational)
// BEHAVIOUR
//  - FSM IDLE -> ACCESS -> RESP -> IDLE; one transaction in flight; min 3 cycles each.
//  - IDLE: if any req_valid, grant one port; its req_ready=1 combinationally that
//    cycle (other port's ready=0); latch addr/wdata/we/size/sign/port; go ACCESS.
//  - Arbitration: only one valid -> that port. Both valid -> port not granted last;
//    last_grant resets to D so C wins first contention.
//  - ACCESS: drive mem_* from latched regs for exactly one cycle; mem_we=we&&!err;
//    capture mem_rdata into rdata reg if load&&!err, else rdata=0; go RESP.
//  - RESP: granted port rsp_valid=1, rdata/err stable; on rsp_ready go IDLE.
//    No new grant while in ACCESS/RESP; req_ready=0 there.
//  - err=1 if size==11; size==01 && addr[0]; size==10 && addr[1:0]!=0; or
//    addr+nbytes > DEPTH (nbytes 1/2/4; compute in 33 bits, no wrap).
//  - Outside ACCESS all mem_* outputs 0 (one-hot all zero, mem_we=0). Size 11 or
//    err in ACCESS: mem_we=0, one-hot still driven for size 00/01/10, 000 for 11.
//  - Reset (async, any state): state=IDLE, last_grant=D, all rsp_valid/err=0,
//    rdata=0, req_ready=0, mem_* =0. A store interrupted in ACCESS is not retried;
//    requester must reissue. req_valid held through reset is granted after release.
//  - Requester may drop req_valid before ready; nothing latched. Once accepted,
//    request fields may change freely.
// TESTING
//  - C store word 0xDEADBEEF @0x10, then C load word @0x10 -> rsp rdata=0xDEADBEEF, err=0,
//    mem_we high exactly 1 cycle, 3 cycles accept-to-rsp_valid with rsp_ready=1.
//  - C and D valid same cycle after reset -> C granted first, D next; repeat -> alternates.
//  - Store byte 0x80 @0x20, load byte sign=1 -> 0xFFFFFF80; sign=0 -> 0x00000080.
//  - Load half @0x21, word @0x22, size=11, word @DEPTH-2 -> err=1, rdata=0, mem_we never 1.
//  - Hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, other port's req_ready=0.
//  - Assert rst_n=0 during ACCESS of a store -> outputs zero immediately, FSM IDLE,
//    next request served normally.

Source files
------------

// File: rtl/sr_mem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port byte memory (sr_mem).
// One transaction in flight: IDLE (grant/latch) -> ACCESS (drive memory) -> RESP (hold response).
module sr_mem_arbiter #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  // core port
  input  logic        c_req_valid,
  output logic        c_req_ready,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic        c_we,
  input  logic [1:0]  c_size,
  input  logic        c_sign,
  output logic        c_rsp_valid,
  input  logic        c_rsp_ready,
  output logic [31:0] c_rdata,
  output logic        c_err,
  // debug port
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_sign,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // memory side
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_sign,
  output logic        mem_byte_w,
  output logic        mem_half_w,
  output logic        mem_word_w,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic        PORT_C  = 1'b0;
  localparam logic        PORT_D  = 1'b1;
  localparam logic [32:0] DEPTH33 = 33'(DEPTH);

  state_e      state_q, state_d;
  logic        port_q, last_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        we_q, sign_q, err_q;

  logic        gnt_vld, gnt_port, rsp_ready_sel, in_acc;
  logic [2:0]  nbytes;
  logic [32:0] end_addr;
  logic        acc_err;

  // Contention goes to the port not served last; a lone requester always wins.
  // Gating with rst_n keeps req_ready low while reset is held.
  always_comb begin
    if (c_req_valid && d_req_valid) gnt_port = ~last_q;
    else                            gnt_port = d_req_valid;
    gnt_vld = rst_n && (state_q == S_IDLE) && (c_req_valid || d_req_valid);
  end

  assign c_req_ready = gnt_vld && (gnt_port == PORT_C);
  assign d_req_ready = gnt_vld && (gnt_port == PORT_D);

  // Range check runs in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    case (size_q)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    end_addr = {1'b0, addr_q} + {30'd0, nbytes};
    acc_err  = (size_q == 2'b11)
            || (size_q == 2'b01 && addr_q[0])
            || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
            || (end_addr > DEPTH33);
  end

  assign rsp_ready_sel = (port_q == PORT_D) ? d_rsp_ready : c_rsp_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (gnt_vld) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (rsp_ready_sel) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Memory is only touched during ACCESS; a faulting access still shows its size strobe.
  assign in_acc     = (state_q == S_ACCESS);
  assign mem_addr   = in_acc ? addr_q  : 32'd0;
  assign mem_wdata  = in_acc ? wdata_q : 32'd0;
  assign mem_sign   = in_acc && sign_q;
  assign mem_we     = in_acc && we_q && !acc_err;
  assign mem_byte_w = in_acc && (size_q == 2'b00);
  assign mem_half_w = in_acc && (size_q == 2'b01);
  assign mem_word_w = in_acc && (size_q == 2'b10);

  assign c_rsp_valid = (state_q == S_RESP) && (port_q == PORT_C);
  assign d_rsp_valid = (state_q == S_RESP) && (port_q == PORT_D);
  assign c_rdata     = c_rsp_valid ? rdata_q : 32'd0;
  assign d_rdata     = d_rsp_valid ? rdata_q : 32'd0;
  assign c_err       = c_rsp_valid && err_q;
  assign d_err       = d_rsp_valid && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= PORT_D;
      port_q  <= PORT_C;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && gnt_vld) begin
        port_q  <= gnt_port;
        last_q  <= gnt_port;
        addr_q  <= gnt_port ? d_addr  : c_addr;
        wdata_q <= gnt_port ? d_wdata : c_wdata;
        size_q  <= gnt_port ? d_size  : c_size;
        we_q    <= gnt_port ? d_we    : c_we;
        sign_q  <= gnt_port ? d_sign  : c_sign;
      end
      if (in_acc) begin
        err_q   <= acc_err;
        rdata_q <= (!we_q && !acc_err) ? mem_rdata : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// Directed bench for sr_mem_arbiter with a small byte-memory model standing in for sr_mem.
module tb_sr_mem_arbiter;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req_valid, c_req_ready, c_we, c_sign, c_rsp_valid, c_rsp_ready, c_err;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [1:0]  c_size;
  logic        d_req_valid, d_req_ready, d_we, d_sign, d_rsp_valid, d_rsp_ready, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_sign, mem_byte_w, mem_half_w, mem_word_w;

  int nchk = 0;
  int nerr = 0;

  sr_mem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_we(c_we), .c_size(c_size), .c_sign(c_sign), .c_rsp_valid(c_rsp_valid),
    .c_rsp_ready(c_rsp_ready), .c_rdata(c_rdata), .c_err(c_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_we(d_we), .d_size(d_size), .d_sign(d_sign), .d_rsp_valid(d_rsp_valid),
    .d_rsp_ready(d_rsp_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_sign(mem_sign),
    .mem_byte_w(mem_byte_w), .mem_half_w(mem_half_w), .mem_word_w(mem_word_w),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Little-endian byte memory; out-of-range bytes read as zero and are never written.
  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] rb [4];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rb[k] = ((mem_addr + 32'(k)) < 32'(DEPTH)) ? mem[8'(mem_addr + 32'(k))] : 8'h00;
    end
    mem_rdata = 32'd0;
    if (mem_byte_w)      mem_rdata = mem_sign ? {{24{rb[0][7]}}, rb[0]} : {24'd0, rb[0]};
    else if (mem_half_w) mem_rdata = mem_sign ? {{16{rb[1][7]}}, rb[1], rb[0]} : {16'd0, rb[1], rb[0]};
    else if (mem_word_w) mem_rdata = {rb[3], rb[2], rb[1], rb[0]};
  end

  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'(DEPTH)) begin
      mem[8'(mem_addr)] <= mem_wdata[7:0];
      if (mem_half_w || mem_word_w) mem[8'(mem_addr + 32'd1)] <= mem_wdata[15:8];
      if (mem_word_w) begin
        mem[8'(mem_addr + 32'd2)] <= mem_wdata[23:16];
        mem[8'(mem_addr + 32'd3)] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request on port p (0=C, 1=D) with rsp_ready held high; called at posedge+1.
  task automatic xact(input bit p, input logic [31:0] a, input logic [31:0] wd, input bit we,
                      input logic [1:0] sz, input bit sg, output logic [31:0] rd,
                      output bit er, output int lat, output int wc);
    int n;
    logic acc, rv;
    rd = 32'd0; er = 1'b0; lat = 0; wc = 0;
    if (p) begin
      d_req_valid = 1'b1; d_addr = a; d_wdata = wd; d_we = we; d_size = sz; d_sign = sg;
    end else begin
      c_req_valid = 1'b1; c_addr = a; c_wdata = wd; c_we = we; c_size = sz; c_sign = sg;
    end
    #1;
    n = 0;
    acc = p ? d_req_ready : c_req_ready;
    while (!acc && n < 20) begin
      @(posedge clk); #1; n++;
      acc = p ? d_req_ready : c_req_ready;
    end
    chk("accept", 32'(acc), 32'd1);
    if (!acc) begin
      c_req_valid = 1'b0; d_req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    lat = 2;
    // Accepted fields may change freely afterwards.
    c_req_valid = 1'b0; d_req_valid = 1'b0;
    c_addr = 32'hFFFF_FFFC; d_addr = 32'hFFFF_FFFC; c_wdata = 32'h5A5A5A5A; d_wdata = 32'h5A5A5A5A;
    n = 0;
    rv = p ? d_rsp_valid : c_rsp_valid;
    while (!rv && n < 20) begin
      if (mem_we) wc++;
      @(posedge clk); #1; lat++; n++;
      rv = p ? d_rsp_valid : c_rsp_valid;
    end
    chk("rsp_valid", 32'(rv), 32'd1);
    if (mem_we) wc++;
    rd = p ? d_rdata : c_rdata;
    er = p ? d_err : c_err;
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input bit p, input logic [31:0] a, input logic [31:0] wd,
                     input bit we, input logic [1:0] sz, input bit sg,
                     input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] rd;
    bit er;
    int lat, wc;
    xact(p, a, wd, we, sz, sg, rd, er, lat, wc);
    chk({tag, ".rdata"}, rd, exp_rd);
    chk({tag, ".err"}, 32'(er), 32'(exp_err));
    chk({tag, ".we_cycles"}, 32'(wc), (we && !exp_err) ? 32'd1 : 32'd0);
    chk({tag, ".latency"}, 32'(lat), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    c_req_valid = 1'b1; c_addr = 32'd0; c_wdata = 32'd0; c_we = 1'b0; c_size = 2'b10; c_sign = 1'b0;
    d_req_valid = 1'b1; d_addr = 32'd0; d_wdata = 32'd0; d_we = 1'b0; d_size = 2'b10; d_sign = 1'b0;
    c_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state, with both requests held through reset.
    chk("rst.ready", {30'd0, c_req_ready, d_req_ready}, 32'd0);
    chk("rst.rsp_valid", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
    chk("rst.mem_ctl", {28'd0, mem_we, mem_byte_w, mem_half_w, mem_word_w}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.rdata", c_rdata | d_rdata, 32'd0);
    rst_n = 1'b1;

    // Held requests are served after release; C wins first contention, then they alternate.
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (!(c_req_ready || d_req_ready) && n < 10) begin
        @(posedge clk); #1; n++;
      end
      chk("arb.grant", {30'd0, c_req_ready, d_req_ready}, (k % 2 == 0) ? 32'd2 : 32'd1);
      @(posedge clk);
    end
    #1;
    c_req_valid = 1'b0; d_req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    // Basic store/load.
    run("st_w", 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 32'd0, 1'b0);
    run("ld_w", 1'b0, 32'h10, 32'd0, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

    // Byte store uses only the low byte; sign control on loads.
    run("clr_w", 1'b1, 32'h20, 32'h00000000, 1'b1, 2'b10, 1'b0, 32'd0, 1'b0);
    run("st_b", 1'b0, 32'h20, 32'hAAAAAA80, 1'b1, 2'b00, 1'b0, 32'd0, 1'b0);
    run("ld_bs", 1'b0, 32'h20, 32'd0, 1'b0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0);
    run("ld_bu", 1'b0, 32'h20, 32'd0, 1'b0, 2'b00, 1'b0, 32'h00000080, 1'b0);
    run("ld_w20", 1'b1, 32'h20, 32'd0, 1'b0, 2'b10, 1'b0, 32'h00000080, 1'b0);

    // Faults: misalignment, illegal size, out of range.
    run("e_half21", 1'b0, 32'h21, 32'd0, 1'b0, 2'b01, 1'b0, 32'd0, 1'b1);
    run("e_word22", 1'b0, 32'h22, 32'h12345678, 1'b1, 2'b10, 1'b0, 32'd0, 1'b1);
    run("e_size11", 1'b1, 32'h0, 32'h12345678, 1'b1, 2'b11, 1'b0, 32'd0, 1'b1);
    run("e_wordtop", 1'b0, 32'(DEPTH - 2), 32'h12345678, 1'b1, 2'b10, 1'b0, 32'd0, 1'b1);
    run("e_range", 1'b1, 32'(DEPTH), 32'd0, 1'b0, 2'b10, 1'b0, 32'd0, 1'b1);
    run("e_halfend", 1'b0, 32'(DEPTH - 1), 32'd0, 1'b0, 2'b01, 1'b0, 32'd0, 1'b1);
    run("e_wrap", 1'b0, 32'hFFFF_FFFC, 32'd0, 1'b0, 2'b10, 1'b0, 32'd0, 1'b1);
    run("ld_w20b", 1'b0, 32'h20, 32'd0, 1'b0, 2'b10, 1'b0, 32'h00000080, 1'b0);
    // Highest legal accesses.
    run("st_top_b", 1'b1, 32'(DEPTH - 1), 32'h000000C3, 1'b1, 2'b00, 1'b0, 32'd0, 1'b0);
    run("ld_top_b", 1'b1, 32'(DEPTH - 1), 32'd0, 1'b0, 2'b00, 1'b0, 32'h000000C3, 1'b0);
    run("st_top_w", 1'b0, 32'(DEPTH - 4), 32'h01020304, 1'b1, 2'b10, 1'b0, 32'd0, 1'b0);
    run("ld_top_h", 1'b0, 32'(DEPTH - 2), 32'd0, 1'b0, 2'b01, 1'b1, 32'h00000102, 1'b0);

    // Response backpressure: D holds its response, C must wait.
    d_rsp_ready = 1'b0;
    d_req_valid = 1'b1; d_addr = 32'h10; d_we = 1'b0; d_size = 2'b10; d_sign = 1'b0;
    #1;
    chk("stall.d_ready", 32'(d_req_ready), 32'd1);
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    c_req_valid = 1'b1; c_addr = 32'h10; c_we = 1'b0; c_size = 2'b10; c_sign = 1'b0;
    #1;
    chk("stall.c_ready_acc", 32'(c_req_ready), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall.d_rsp_valid", 32'(d_rsp_valid), 32'd1);
      chk("stall.d_rdata", d_rdata, 32'hDEADBEEF);
      chk("stall.c_ready", 32'(c_req_ready), 32'd0);
      @(posedge clk); #1;
    end
    d_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall.c_granted", 32'(c_req_ready), 32'd1);
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("stall.c_rsp", c_rsp_valid ? c_rdata : 32'hBAD0BAD0, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Reset in the middle of a store's ACCESS cycle: the store is dropped.
    run("pre_st", 1'b0, 32'h40, 32'h11111111, 1'b1, 2'b10, 1'b0, 32'd0, 1'b0);
    c_req_valid = 1'b1; c_addr = 32'h40; c_wdata = 32'hCAFEF00D; c_we = 1'b1; c_size = 2'b10;
    #1;
    chk("rstacc.accept", 32'(c_req_ready), 32'd1);
    @(posedge clk); #1;
    c_req_valid = 1'b0;
    chk("rstacc.mem_we", 32'(mem_we), 32'd1);
    chk("rstacc.mem_addr", mem_addr, 32'h40);
    rst_n = 1'b0;
    #1;
    chk("rstacc.mem_ctl", {28'd0, mem_we, mem_byte_w, mem_half_w, mem_word_w}, 32'd0);
    chk("rstacc.mem_addr0", mem_addr, 32'd0);
    @(posedge clk); #1;
    chk("rstacc.rsp_valid", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
    rst_n = 1'b1;
    run("post_ld", 1'b0, 32'h40, 32'd0, 1'b0, 2'b10, 1'b0, 32'h11111111, 1'b0);
    run("post_st", 1'b0, 32'h40, 32'hCAFEF00D, 1'b1, 2'b10, 1'b0, 32'd0, 1'b0);
    run("post_ld2", 1'b1, 32'h40, 32'd0, 1'b0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
